execute_stage: RTL and testbench

- Execute stage of the 5-stage pipelined RV32I core, directly downstream of the decode→execute pipeline register; consumes its E-suffixed outputs.
- Applies forwarding to both operands, runs the ALU, and resolves branches and jumps (PCSrcE, PCTargetE back to fetch).
- Contains the execute→memory pipeline register, with stall and flush, feeding the memory stage.

---
 rtl/execute_stage.sv | 163 ++++++++++++++++
 tb/tb_execute_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage of the 5-stage RV32I pipeline.
// Forwards both operands, runs the ALU, resolves branches/jumps combinationally
// back to fetch, and holds the execute->memory pipeline register (stall/flush).
// Optional build macro EXEC_PERF_CNT_EN adds BranchCount/TakenCount outputs
// counting branches (and taken branches) that actually advance into memory.

module execute_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  // Control from decode->execute register
  input  logic                      RegWriteE,
  input  logic                      ResultSrcE,
  input  logic                      MemWriteE,
  input  logic                      JumpE,
  input  logic                      BranchE,
  input  logic [2:0]                ALUControlE,
  input  logic                      ALUSrcE,
  input  logic                      MUXJUMPE,
  input  logic                      JUMPRTE,
  input  logic                      BranchMUXE,
  // Datapath from decode->execute register
  input  logic [DATA_WIDTH-1:0]     RD1E,
  input  logic [DATA_WIDTH-1:0]     RD2E,
  input  logic [DATA_WIDTH-1:0]     PCE,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [DATA_WIDTH-1:0]     ImmExtE,
  input  logic [DATA_WIDTH-1:0]     PCPlus4E,
  // Hazard unit
  input  logic [1:0]                ForwardAE,
  input  logic [1:0]                ForwardBE,
  input  logic [DATA_WIDTH-1:0]     ResultW,
  input  logic                      StallM,
  input  logic                      FlushM,
  // Redirect to fetch
  output logic                      PCSrcE,
  output logic [DATA_WIDTH-1:0]     PCTargetE,
  // Execute->memory register
  output logic                      RegWriteM,
  output logic                      ResultSrcM,
  output logic                      MemWriteM,
  output logic                      JUMPRTM,
  output logic [DATA_WIDTH-1:0]     ALUResultM,
  output logic [DATA_WIDTH-1:0]     WriteDataM,
  output logic [REG_ADDR_WIDTH-1:0] RdM,
  output logic [DATA_WIDTH-1:0]     PCPlus4M
`ifdef EXEC_PERF_CNT_EN
  ,
  output logic [31:0]               BranchCount,
  output logic [31:0]               TakenCount
`endif
);

  // ALU operation encodings
  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluXor = 3'b100;
  localparam logic [2:0] AluSlt = 3'b101;
  localparam logic [2:0] AluSll = 3'b110;
  localparam logic [2:0] AluSrl = 3'b111;

  logic [DATA_WIDTH-1:0] src_a;
  logic [DATA_WIDTH-1:0] fwd_b;
  logic [DATA_WIDTH-1:0] src_b;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [4:0]            shamt;
  logic                  zero;
  logic                  load_en;

  // Operand forwarding; 11 falls back to the register value
  always_comb begin
    src_a = RD1E;
    fwd_b = RD2E;
    unique case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
    unique case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = RD2E;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExtE : fwd_b;
  assign shamt = src_b[4:0];

  // ALU, all arithmetic modulo 2^DATA_WIDTH
  always_comb begin
    alu_result = '0;
    unique case (ALUControlE)
      AluAdd:  alu_result = src_a + src_b;
      AluSub:  alu_result = src_a - src_b;
      AluAnd:  alu_result = src_a & src_b;
      AluOr:   alu_result = src_a | src_b;
      AluXor:  alu_result = src_a ^ src_b;
      AluSlt:  alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      AluSll:  alu_result = src_a << shamt;
      AluSrl:  alu_result = src_a >> shamt;
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  // Branch/jump resolution; jalr target has bit 0 cleared
  always_comb begin
    PCSrcE    = JumpE | (BranchE & (zero ^ BranchMUXE));
    PCTargetE = MUXJUMPE ? {alu_result[DATA_WIDTH-1:1], 1'b0} : (PCE + ImmExtE);
  end

  // Register advances only when neither flushed nor stalled
  assign load_en = !FlushM && !StallM;

  // Execute->memory register: rst > FlushM > StallM > load
  always_ff @(posedge clk) begin
    if (rst || FlushM) begin
      RegWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      MemWriteM  <= 1'b0;
      JUMPRTM    <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      RdM        <= '0;
      PCPlus4M   <= '0;
    end else if (!StallM) begin
      RegWriteM  <= RegWriteE;
      ResultSrcM <= ResultSrcE;
      MemWriteM  <= MemWriteE;
      JUMPRTM    <= JUMPRTE;
      ALUResultM <= alu_result;
      WriteDataM <= fwd_b;
      RdM        <= RdE;
      PCPlus4M   <= PCPlus4E;
    end
  end

`ifdef EXEC_PERF_CNT_EN
  // Branch statistics, counted only on edges where the register loads
  always_ff @(posedge clk) begin
    if (rst) begin
      BranchCount <= '0;
      TakenCount  <= '0;
    end else if (load_en) begin
      if (BranchE) begin
        BranchCount <= BranchCount + 32'd1;
      end
      if (BranchE && PCSrcE) begin
        TakenCount <= TakenCount + 32'd1;
      end
    end
  end
`else
  logic unused_load_en;
  assign unused_load_en = load_en;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage. Define EXEC_PERF_CNT_EN to also
// exercise the branch counters.

module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE;
  logic [2:0]  ALUControlE;
  logic        ALUSrcE, MUXJUMPE, JUMPRTE, BranchMUXE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallM, FlushM;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, ResultSrcM, MemWriteM, JUMPRTM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
`ifdef EXEC_PERF_CNT_EN
  logic [31:0] BranchCount, TakenCount;
`endif

  int checks = 0;
  int errors = 0;

  execute_stage #(
    .DATA_WIDTH     (32),
    .REG_ADDR_WIDTH (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteE   (RegWriteE),
    .ResultSrcE  (ResultSrcE),
    .MemWriteE   (MemWriteE),
    .JumpE       (JumpE),
    .BranchE     (BranchE),
    .ALUControlE (ALUControlE),
    .ALUSrcE     (ALUSrcE),
    .MUXJUMPE    (MUXJUMPE),
    .JUMPRTE     (JUMPRTE),
    .BranchMUXE  (BranchMUXE),
    .RD1E        (RD1E),
    .RD2E        (RD2E),
    .PCE         (PCE),
    .RdE         (RdE),
    .ImmExtE     (ImmExtE),
    .PCPlus4E    (PCPlus4E),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .ResultW     (ResultW),
    .StallM      (StallM),
    .FlushM      (FlushM),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .RegWriteM   (RegWriteM),
    .ResultSrcM  (ResultSrcM),
    .MemWriteM   (MemWriteM),
    .JUMPRTM     (JUMPRTM),
    .ALUResultM  (ALUResultM),
    .WriteDataM  (WriteDataM),
    .RdM         (RdM),
    .PCPlus4M    (PCPlus4M)
`ifdef EXEC_PERF_CNT_EN
    ,
    .BranchCount (BranchCount),
    .TakenCount  (TakenCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle so sampling is away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_m_zero(input string tag);
    check({tag, " RegWriteM"},  {31'd0, RegWriteM},  32'd0);
    check({tag, " ResultSrcM"}, {31'd0, ResultSrcM}, 32'd0);
    check({tag, " MemWriteM"},  {31'd0, MemWriteM},  32'd0);
    check({tag, " JUMPRTM"},    {31'd0, JUMPRTM},    32'd0);
    check({tag, " ALUResultM"}, ALUResultM,          32'd0);
    check({tag, " WriteDataM"}, WriteDataM,          32'd0);
    check({tag, " RdM"},        {27'd0, RdM},        32'd0);
    check({tag, " PCPlus4M"},   PCPlus4M,            32'd0);
  endtask

  task automatic clear_inputs();
    RegWriteE = 0; ResultSrcE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0;
    ALUControlE = 3'b000; ALUSrcE = 0; MUXJUMPE = 0; JUMPRTE = 0; BranchMUXE = 0;
    RD1E = 0; RD2E = 0; PCE = 0; RdE = 0; ImmExtE = 0; PCPlus4E = 0;
    ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = 0; StallM = 0; FlushM = 0;
  endtask

  // Load one ALU op with plain operands and check the registered result
  task automatic alu_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    ALUControlE = op; RD1E = a; RD2E = b;
    tick();
    check(tag, ALUResultM, exp);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick();
    tick();
    check_m_zero("reset");
    rst = 0;

    // ADD with no forwarding
    RD1E = 5; RD2E = 7; RegWriteE = 1; RdE = 5'd3; MemWriteE = 1; ResultSrcE = 1;
    #1;
    check("add PCSrcE", {31'd0, PCSrcE}, 32'd0);
    check("add PCTargetE", PCTargetE, 32'd0);
    tick();
    check("add ALUResultM", ALUResultM, 32'd12);
    check("add WriteDataM", WriteDataM, 32'd7);
    check("add RegWriteM", {31'd0, RegWriteM}, 32'd1);
    check("add MemWriteM", {31'd0, MemWriteM}, 32'd1);
    check("add ResultSrcM", {31'd0, ResultSrcM}, 32'd1);
    check("add RdM", {27'd0, RdM}, 32'd3);
    MemWriteE = 0; ResultSrcE = 0;

    // Forwarding: A from ALUResultM (0x10), B from ResultW (3), SUB -> 0x0D
    alu_op("prep ALUResultM", 3'b000, 32'h10, 32'h0, 32'h10);
    ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'd3;
    ALUControlE = 3'b001; RD1E = 32'hFF; RD2E = 32'hFF;
    tick();
    check("fwd sub ALUResultM", ALUResultM, 32'h0D);
    check("fwd WriteDataM", WriteDataM, 32'd3);

    // Select 11 means register value
    ForwardAE = 2'b11; ForwardBE = 2'b11;
    alu_op("fwd11 or", 3'b011, 32'h8, 32'h2, 32'hA);
    ForwardAE = 2'b00; ForwardBE = 2'b00;

    // Immediate operand; WriteData still carries rs2
    ALUSrcE = 1; ImmExtE = 32'd100;
    alu_op("imm add", 3'b000, 32'd1, 32'd55, 32'd101);
    check("imm WriteDataM", WriteDataM, 32'd55);
    ALUSrcE = 0; ImmExtE = 0;

    alu_op("and",      3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu_op("xor",      3'b100, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
    alu_op("slt neg",  3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1);
    alu_op("slt pos",  3'b101, 32'h0000_0001, 32'hFFFF_FFFF, 32'd0);
    alu_op("sll",      3'b110, 32'd1, 32'h24, 32'd16);
    alu_op("srl",      3'b111, 32'h8000_0000, 32'd31, 32'd1);
    alu_op("add wrap", 3'b000, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_op("sub wrap", 3'b001, 32'd0, 32'd1, 32'hFFFF_FFFF);

    // beq / bne with equal operands
    BranchE = 1; ALUControlE = 3'b001; RD1E = 4; RD2E = 4; PCE = 32'h100; ImmExtE = 32'h20;
    BranchMUXE = 0;
    #1;
    check("beq PCSrcE", {31'd0, PCSrcE}, 32'd1);
    check("beq PCTargetE", PCTargetE, 32'h120);
    BranchMUXE = 1;
    #1;
    check("bne eq PCSrcE", {31'd0, PCSrcE}, 32'd0);
    RD2E = 5;
    #1;
    check("bne ne PCSrcE", {31'd0, PCSrcE}, 32'd1);
    BranchMUXE = 0;
    #1;
    check("beq ne PCSrcE", {31'd0, PCSrcE}, 32'd0);
    BranchE = 0;

    // jalr
    JumpE = 1; MUXJUMPE = 1; ALUSrcE = 1; ALUControlE = 3'b000; RD1E = 32'h203;
    ImmExtE = 0; JUMPRTE = 1; PCPlus4E = 32'h108;
    #1;
    check("jalr PCSrcE", {31'd0, PCSrcE}, 32'd1);
    check("jalr PCTargetE", PCTargetE, 32'h202);
    tick();
    check("jalr JUMPRTM", {31'd0, JUMPRTM}, 32'd1);
    check("jalr PCPlus4M", PCPlus4M, 32'h108);
    JumpE = 0; MUXJUMPE = 0; ALUSrcE = 0; JUMPRTE = 0; PCE = 0; PCPlus4E = 0;

    // Stall holds, flush wins over stall
    RdE = 5'd9; RD1E = 32'h40; RD2E = 32'h1; ALUControlE = 3'b000;
    tick();
    check("pre-stall RdM", {27'd0, RdM}, 32'd9);
    check("pre-stall ALUResultM", ALUResultM, 32'h41);
    StallM = 1; RdE = 5'd12; RD1E = 32'h77; RD2E = 32'h2;
    tick();
    check("stall RdM", {27'd0, RdM}, 32'd9);
    check("stall ALUResultM", ALUResultM, 32'h41);
    check("stall WriteDataM", WriteDataM, 32'h1);
    // Forward 10 during stall sees the held ALUResultM
    ForwardAE = 2'b10; MUXJUMPE = 1; ALUSrcE = 1; ImmExtE = 32'h4;
    #1;
    check("stall fwd PCTargetE", PCTargetE, 32'h44);
    ForwardAE = 2'b00; MUXJUMPE = 0; ALUSrcE = 0; ImmExtE = 0;
    FlushM = 1;
    tick();
    check_m_zero("flush+stall");
    StallM = 0; FlushM = 0;

    // Reset mid-operation
    RegWriteE = 1; RdE = 5'd7; RD1E = 32'h5; RD2E = 32'h6; JUMPRTE = 1; PCPlus4E = 32'h44;
    tick();
    check("pre-rst RdM", {27'd0, RdM}, 32'd7);
    rst = 1;
    tick();
    check_m_zero("mid reset");
    rst = 0;

`ifdef EXEC_PERF_CNT_EN
    clear_inputs();
    check("cnt reset BranchCount", BranchCount, 32'd0);
    check("cnt reset TakenCount", TakenCount, 32'd0);
    // Branch 1: taken, loads
    BranchE = 1; ALUControlE = 3'b001; RD1E = 3; RD2E = 3;
    tick();
    check("cnt1 BranchCount", BranchCount, 32'd1);
    check("cnt1 TakenCount", TakenCount, 32'd1);
    // Branch 2: taken, stalled -> not counted
    StallM = 1;
    tick();
    check("cnt2 BranchCount", BranchCount, 32'd1);
    check("cnt2 TakenCount", TakenCount, 32'd1);
    StallM = 0;
    // Branch 3: not taken, loads
    RD2E = 4;
    tick();
    check("cnt3 BranchCount", BranchCount, 32'd2);
    check("cnt3 TakenCount", TakenCount, 32'd1);
    BranchE = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
